// File: rtl/adex_spike_monitor_if.sv
// Report channel of the AdEx spike monitor: one window record per
// valid/ready transfer.
interface adex_spike_monitor_if #(
    parameter int CNT_W = 8,
    parameter int ISI_W = 12
);
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] rep_count;
    logic [ISI_W-1:0] rep_isi;
    logic [7:0]       rep_vmpeak;

    modport master (
        output out_valid,
        output rep_count,
        output rep_isi,
        output rep_vmpeak,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  rep_count,
        input  rep_isi,
        input  rep_vmpeak,
        output out_ready
    );
endinterface

// File: rtl/adex_spike_monitor.sv
// AdEx spike monitor: edge detect, ISI measure, windowed spike count.
// ADEX_MON_VMPEAK_EN adds a per-window peak of vm8_in to the record.
module adex_spike_monitor #(
    parameter int CNT_W = 8,
    parameter int ISI_W = 12,
    parameter int WIN_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 spike_in,
    input  logic [7:0]           vm8_in,
    input  logic [WIN_W-1:0]     win_len,
    input  logic                 clr_ovf,
    adex_spike_monitor_if.master rep,
    output logic                 spike_edge,
    output logic                 ovf
);
    typedef enum logic {W_IDLE, W_RUN} win_state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [ISI_W-1:0] ISI_MAX = '1;

    win_state_t       state;
    logic             spike_prev;
    logic             have_prev;
    logic [ISI_W-1:0] isi_cnt;
    logic [ISI_W-1:0] last_isi;
    logic [WIN_W-1:0] win_q;
    logic [WIN_W-1:0] win_cnt;
    logic [CNT_W-1:0] spk_cnt;
    logic             valid_q;
    logic [CNT_W-1:0] count_q;
    logic [ISI_W-1:0] isi_q;

    logic             spk_edge;
    logic [WIN_W-1:0] win_len1;
    logic [WIN_W-1:0] q_cur;
    logic [WIN_W-1:0] cnt_cur;
    logic [CNT_W-1:0] spk_cur;
    logic [CNT_W-1:0] spk_nxt;
    logic [ISI_W-1:0] isi_inc;
    logic [ISI_W-1:0] last_isi_nxt;
    logic             close;
    logic             accept;
    logic             drop;

    // In W_IDLE the current cycle is window cycle 0 of a freshly latched window.
    always_comb begin
        spk_edge     = spike_in & ~spike_prev & enable;
        win_len1     = (win_len == '0) ? WIN_W'(1) : win_len;
        q_cur        = (state == W_IDLE) ? win_len1 : win_q;
        cnt_cur      = (state == W_IDLE) ? '0 : win_cnt;
        spk_cur      = (state == W_IDLE) ? '0 : spk_cnt;
        spk_nxt      = (spk_edge && spk_cur != CNT_MAX) ? spk_cur + 1'b1 : spk_cur;
        isi_inc      = (isi_cnt == ISI_MAX) ? isi_cnt : isi_cnt + 1'b1;
        last_isi_nxt = (spk_edge & have_prev) ? isi_inc : last_isi;
        close        = enable & (cnt_cur == q_cur - WIN_W'(1));
        accept       = ~valid_q | rep.out_ready;
        drop         = close & ~accept;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= W_IDLE;
            spike_prev <= 1'b0;
            spike_edge <= 1'b0;
            have_prev  <= 1'b0;
            isi_cnt    <= '0;
            last_isi   <= '0;
            win_q      <= '0;
            win_cnt    <= '0;
            spk_cnt    <= '0;
            valid_q    <= 1'b0;
            count_q    <= '0;
            isi_q      <= '0;
            ovf        <= 1'b0;
        end else begin
            spike_prev <= spike_in;
            spike_edge <= spk_edge;
            if (enable) begin
                isi_cnt  <= spk_edge ? '0 : isi_inc;
                last_isi <= last_isi_nxt;
                state    <= W_RUN;
                if (spk_edge)
                    have_prev <= 1'b1;
                if (close) begin
                    win_cnt <= '0;
                    spk_cnt <= '0;
                    win_q   <= win_len1;
                end else begin
                    win_cnt <= cnt_cur + WIN_W'(1);
                    spk_cnt <= spk_nxt;
                    win_q   <= q_cur;
                end
            end
            if (close && accept) begin
                valid_q <= 1'b1;
                count_q <= spk_nxt;
                isi_q   <= last_isi_nxt;
            end else if (valid_q && rep.out_ready) begin
                valid_q <= 1'b0;
            end
            if (drop)
                ovf <= 1'b1;
            else if (clr_ovf)
                ovf <= 1'b0;
        end
    end

    assign rep.out_valid = valid_q;
    assign rep.rep_count = count_q;
    assign rep.rep_isi   = isi_q;

`ifdef ADEX_MON_VMPEAK_EN
    logic [7:0] peak;
    logic [7:0] pk_base;
    logic [7:0] pk_nxt;
    logic [7:0] vmpeak_q;

    always_comb begin
        pk_base = (state == W_IDLE) ? 8'd0 : peak;
        pk_nxt  = (vm8_in > pk_base) ? vm8_in : pk_base;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            peak     <= '0;
            vmpeak_q <= '0;
        end else begin
            if (enable)
                peak <= close ? 8'd0 : pk_nxt;
            if (close && accept)
                vmpeak_q <= pk_nxt;
        end
    end

    assign rep.rep_vmpeak = vmpeak_q;
`else
    logic unused_vm8;
    assign unused_vm8     = ^vm8_in;
    assign rep.rep_vmpeak = '0;
`endif
endmodule

// File: tb/tb_adex_spike_monitor.sv
// Directed self-checking bench for adex_spike_monitor.
module tb_adex_spike_monitor;
    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        spike_in;
    logic [7:0]  vm8_in;
    logic [15:0] win_len;
    logic        clr_ovf;
    logic        spike_edge;
    logic        ovf;
    int          n_chk = 0;
    int          n_err = 0;

`ifdef ADEX_MON_VMPEAK_EN
    localparam bit VP = 1'b1;
`else
    localparam bit VP = 1'b0;
`endif

    adex_spike_monitor_if #(.CNT_W(8), .ISI_W(12)) rif ();

    adex_spike_monitor #(.CNT_W(8), .ISI_W(12), .WIN_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .spike_in   (spike_in),
        .vm8_in     (vm8_in),
        .win_len    (win_len),
        .clr_ovf    (clr_ovf),
        .rep        (rif.master),
        .spike_edge (spike_edge),
        .ovf        (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        enable        = 1'b0;
        spike_in      = 1'b0;
        vm8_in        = 8'd0;
        clr_ovf       = 1'b0;
        rif.out_ready = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        win_len = 16'd20;
        do_reset();
        chk("rst_valid", 32'(rif.out_valid), 0);
        chk("rst_count", 32'(rif.rep_count), 0);
        chk("rst_isi", 32'(rif.rep_isi), 0);
        chk("rst_edge", 32'(spike_edge), 0);
        chk("rst_ovf", 32'(ovf), 0);

        // basic window: edges at 3 and 10, close at 19
        enable = 1'b1;
        for (int c = 0; c <= 20; c++) begin
            spike_in = (c >= 3 && c <= 5) || (c >= 10 && c <= 12);
            tick();
            chk("b_edge", 32'(spike_edge), 32'(c == 3 || c == 10));
            chk("b_valid", 32'(rif.out_valid), 32'(c == 19));
            if (c == 19) begin
                chk("b_count", 32'(rif.rep_count), 2);
                chk("b_isi", 32'(rif.rep_isi), 7);
            end
        end

        // edge on the closing cycle
        do_reset();
        win_len = 16'd8;
        enable  = 1'b1;
        for (int c = 0; c <= 15; c++) begin
            spike_in = (c == 7);
            tick();
            chk("c_valid", 32'(rif.out_valid), 32'(c == 7 || c == 15));
            if (c == 7) chk("c_count1", 32'(rif.rep_count), 1);
            if (c == 15) chk("c_count2", 32'(rif.rep_count), 0);
        end

        // backpressure and overflow
        do_reset();
        win_len       = 16'd4;
        enable        = 1'b1;
        rif.out_ready = 1'b0;
        for (int c = 0; c <= 11; c++) begin
            spike_in      = (c == 1 || c == 4 || c == 6);
            clr_ovf       = (c == 10);
            rif.out_ready = (c == 11);
            tick();
            if (c == 3) begin
                chk("o_valid1", 32'(rif.out_valid), 1);
                chk("o_count1", 32'(rif.rep_count), 1);
                chk("o_ovf0", 32'(ovf), 0);
            end
            if (c == 9) begin
                chk("o_hold_v", 32'(rif.out_valid), 1);
                chk("o_hold_c", 32'(rif.rep_count), 1);
                chk("o_hold_i", 32'(rif.rep_isi), 0);
                chk("o_ovf1", 32'(ovf), 1);
            end
            if (c == 10) chk("o_clr", 32'(ovf), 0);
            if (c == 11) begin
                chk("o_valid3", 32'(rif.out_valid), 1);
                chk("o_count3", 32'(rif.rep_count), 0);
                chk("o_isi3", 32'(rif.rep_isi), 2);
                chk("o_ovf_ok", 32'(ovf), 0);
            end
        end

        // saturation of count and ISI
        do_reset();
        win_len = 16'd1000;
        enable  = 1'b1;
        for (int c = 0; c < 6000; c++) begin
            spike_in = (c < 1000) ? c[0] : (c == 5999);
            tick();
            if (c == 999) begin
                chk("s_count", 32'(rif.rep_count), 255);
                chk("s_isi2", 32'(rif.rep_isi), 2);
            end
            if (c == 5999) begin
                chk("s_isi_sat", 32'(rif.rep_isi), 4095);
                chk("s_count1", 32'(rif.rep_count), 1);
            end
        end

        // enable freeze for 50 cycles, then reset mid-window
        do_reset();
        win_len = 16'd20;
        for (int t = 0; t <= 77; t++) begin
            enable   = !(t >= 10 && t < 60);
            spike_in = (t == 2 || t == 5 || (t >= 20 && t <= 22) || t == 72);
            tick();
            chk("f_valid", 32'(rif.out_valid), 32'(t == 69));
            if (t == 21) chk("f_noedge", 32'(spike_edge), 0);
            if (t == 69) begin
                chk("f_count", 32'(rif.rep_count), 2);
                chk("f_isi", 32'(rif.rep_isi), 3);
            end
        end
        #2;
        reset = 1'b1;
        #1;
        chk("r_count", 32'(rif.rep_count), 0);
        chk("r_isi", 32'(rif.rep_isi), 0);
        chk("r_valid", 32'(rif.out_valid), 0);
        chk("r_edge", 32'(spike_edge), 0);
        chk("r_vmpeak", 32'(rif.rep_vmpeak), 0);
        tick();
        reset    = 1'b0;
        spike_in = 1'b0;
        enable   = 1'b1;
        for (int e = 0; e <= 20; e++) begin
            spike_in = (e == 5 || e == 6);
            tick();
            chk("r_win_v", 32'(rif.out_valid), 32'(e == 19));
            if (e == 19) begin
                chk("r_win_c", 32'(rif.rep_count), 1);
                chk("r_win_i", 32'(rif.rep_isi), 0);
            end
        end

        // membrane peak over a window
        do_reset();
        win_len = 16'd40;
        enable  = 1'b1;
        for (int c = 0; c < 80; c++) begin
            if (c < 20)      vm8_in = 8'(10 + 10 * c);
            else if (c < 40) vm8_in = 8'(190 - 7 * (c - 20));
            else             vm8_in = 8'd30;
            tick();
            if (c == 39) chk("p_peak1", 32'(rif.rep_vmpeak), VP ? 200 : 0);
            if (c == 79) chk("p_peak2", 32'(rif.rep_vmpeak), VP ? 30 : 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
